// File: rtl/fetch_stage_pkg.sv
// Shared defines for the front end: instruction/PC geometry, the opcode field
// position consumed by the decode controller, the opcode constants, and the
// fetch FSM state encoding.
package fetch_stage_pkg;

  localparam int INSTR_W = 19;
  localparam int PC_W    = 12;
  localparam int CNT_W   = 16;
  localparam int OPC_MSB = 18;
  localparam int OPC_LSB = 13;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

  // Opcode constants used by the decode controller.
  localparam logic [OPC_W-1:0] OPC_NOP  = 6'h00;
  localparam logic [OPC_W-1:0] OPC_ADD  = 6'h01;
  localparam logic [OPC_W-1:0] OPC_SUB  = 6'h02;
  localparam logic [OPC_W-1:0] OPC_LOAD = 6'h10;
  localparam logic [OPC_W-1:0] OPC_STOR = 6'h11;
  localparam logic [OPC_W-1:0] OPC_BEQ  = 6'h20;
  localparam logic [OPC_W-1:0] OPC_JMP  = 6'h21;

  typedef enum logic [1:0] {
    FS_BOOT    = 2'd0,
    FS_RUN     = 2'd1,
    FS_STALLED = 2'd2
  } fetch_state_e;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry skid buffer that parks the memory word which was already in
// flight when decode raised a stall, so it can be delivered on release.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset (clears full only)
//   capture_i     : load instr_i/pc_i and mark full
//   drain_i       : entry consumed by IF/ID this cycle, mark empty
//   clear_i       : redirect flush, mark empty (wins over capture)
//   instr_i, pc_i : word and its address to park
//   instr_o, pc_o : parked word and address
//   full_o        : entry holds a valid instruction
module fetch_skid_buffer
  import fetch_stage_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               capture_i,
  input  logic               drain_i,
  input  logic               clear_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o,
  output logic               full_o
);

  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    pc_q;
  logic               full_q;
  logic               full_d;

  always_comb begin
    full_d = full_q;
    if (clear_i || drain_i) begin
      full_d = 1'b0;
    end else if (capture_i) begin
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
    end else begin
      full_q <= full_d;
    end
  end

  // Payload needs no reset: it is only observed while full_q is set.
  always_ff @(posedge clk_i) begin
    if (capture_i && !clear_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign full_o  = full_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives a synchronous instruction memory from the
// PC register, tracks the one outstanding request, fills the IF/ID register,
// absorbs decode stalls through a one-entry skid buffer (no bubble on a
// one-cycle stall) and services branch redirects with a two-bubble penalty.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   stall           : decode hazard, hold IF/ID and PC
//   branch_taken    : redirect request from execute (beats stall)
//   branch_target   : redirect PC
//   imem_addr       : memory address (= PC register)
//   imem_rd         : memory read enable (high out of reset)
//   imem_data       : memory data, valid one cycle after imem_addr
//   instr_out       : IF/ID instruction, opcode in [18:13]
//   pc_out          : address of instr_out
//   instr_valid     : IF/ID holds a real instruction (0 = bubble)
//   fetch_count     : instructions loaded into IF/ID since reset
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_rd,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc_out,
  output logic               instr_valid,
  output logic [CNT_W-1:0]   fetch_count
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    req_pc_q, req_pc_d;
  logic               req_valid_q, req_valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_out_q, pc_out_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               skid_capture, skid_drain, skid_clear;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc;
  logic               skid_full;

  fetch_skid_buffer u_skid (
    .clk_i     (clk),
    .rst_i     (rst),
    .capture_i (skid_capture),
    .drain_i   (skid_drain),
    .clear_i   (skid_clear),
    .instr_i   (imem_data),
    .pc_i      (req_pc_q),
    .instr_o   (skid_instr),
    .pc_o      (skid_pc),
    .full_o    (skid_full)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    req_valid_d  = req_valid_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    valid_d      = valid_q;
    cnt_d        = cnt_q;
    skid_capture = 1'b0;
    skid_drain   = 1'b0;
    skid_clear   = 1'b0;

    if (branch_taken) begin
      // Flush everything in flight; target data arrives two edges later.
      pc_d        = branch_target;
      req_valid_d = 1'b0;
      skid_clear  = 1'b1;
      valid_d     = 1'b0;
      state_d     = FS_RUN;
    end else begin
      unique case (state_q)
        FS_BOOT: begin
          pc_d        = pc_q + PC_W'(1);
          req_pc_d    = pc_q;
          req_valid_d = 1'b1;
          state_d     = FS_RUN;
        end
        FS_RUN: begin
          if (stall) begin
            // The word for req_pc lands this edge; park it for release.
            skid_capture = req_valid_q;
            req_valid_d  = 1'b0;
            state_d      = FS_STALLED;
          end else begin
            pc_d        = pc_q + PC_W'(1);
            req_pc_d    = pc_q;
            req_valid_d = 1'b1;
            if (req_valid_q) begin
              instr_d  = imem_data;
              pc_out_d = req_pc_q;
              valid_d  = 1'b1;
              cnt_d    = cnt_q + CNT_W'(1);
            end else begin
              valid_d = 1'b0;
            end
          end
        end
        FS_STALLED: begin
          if (!stall) begin
            pc_d        = pc_q + PC_W'(1);
            req_pc_d    = pc_q;
            req_valid_d = 1'b1;
            skid_drain  = 1'b1;
            state_d     = FS_RUN;
            if (skid_full) begin
              instr_d  = skid_instr;
              pc_out_d = skid_pc;
              valid_d  = 1'b1;
              cnt_d    = cnt_q + CNT_W'(1);
            end else begin
              valid_d = 1'b0;
            end
          end
        end
        default: state_d = FS_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FS_BOOT;
      pc_q        <= '0;
      req_pc_q    <= '0;
      req_valid_q <= 1'b0;
      instr_q     <= '0;
      pc_out_q    <= '0;
      valid_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
      instr_q     <= instr_d;
      pc_out_q    <= pc_out_d;
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign imem_rd     = ~rst;
  assign instr_out   = instr_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by a randomized run,
// all compared each cycle against a stream-level model of the fetch stage.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [11:0] branch_target;
  logic [11:0] imem_addr;
  logic        imem_rd;
  logic [18:0] imem_data;
  logic [18:0] instr_out;
  logic [11:0] pc_out;
  logic        instr_valid;
  logic [15:0] fetch_count;

  int total = 0;
  int bad   = 0;

  logic [18:0] salt = '0;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_rd       (imem_rd),
    .imem_data     (imem_data),
    .instr_out     (instr_out),
    .pc_out        (pc_out),
    .instr_valid   (instr_valid),
    .fetch_count   (fetch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [18:0] word(input logic [11:0] a);
    return 19'(a) ^ salt;
  endfunction

  // Synchronous instruction memory: data for an address appears one edge later.
  always @(posedge clk) imem_data <= word(imem_addr);

  // Reference model: the PC, the addresses fetched but not yet delivered,
  // and what IF/ID should show. A cycle either advances the stream (deliver
  // oldest fetched address or a bubble, then fetch PC) or holds for a stall.
  logic [11:0] m_pc;
  logic [11:0] m_q[$];
  logic [18:0] m_instr;
  logic [11:0] m_pcout;
  logic        m_valid;
  logic [15:0] m_cnt;
  bit          m_boot;

  task automatic model_edge(input logic r, input logic s, input logic b, input logic [11:0] t);
    logic [11:0] a;
    if (r) begin
      m_pc = '0; m_q.delete(); m_instr = '0; m_pcout = '0; m_valid = 1'b0;
      m_cnt = '0; m_boot = 1'b1;
    end else if (b) begin
      m_pc = t; m_q.delete(); m_valid = 1'b0; m_boot = 1'b0;
    end else if (m_boot || !s) begin
      if (!m_boot) begin
        if (m_q.size() > 0) begin
          a = m_q.pop_front();
          m_pcout = a; m_instr = word(a); m_valid = 1'b1; m_cnt = m_cnt + 16'd1;
        end else begin
          m_valid = 1'b0;
        end
      end
      m_q.push_back(m_pc);
      m_pc = m_pc + 12'd1;
      m_boot = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    chk("pc_out",      32'(pc_out),      32'(m_pcout));
    chk("instr_out",   32'(instr_out),   32'(m_instr));
    chk("fetch_count", 32'(fetch_count), 32'(m_cnt));
    chk("imem_addr",   32'(imem_addr),   32'(m_pc));
    chk("imem_rd",     32'(imem_rd),     32'(!rst));
  endtask

  task automatic tick(input logic r, input logic s, input logic b, input logic [11:0] t);
    rst = r; stall = s; branch_taken = b; branch_target = t;
    @(posedge clk);
    model_edge(r, s, b, t);
    #1;
    check_all();
  endtask

  initial begin
    logic [15:0] c0;
    logic [11:0] p0;
    logic        r, s, b;
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    m_pc = '0; m_instr = '0; m_pcout = '0; m_valid = 1'b0; m_cnt = '0; m_boot = 1'b1;

    // Reset, with a stall and a redirect held in flight.
    tick(1, 1, 1, 12'h123);
    tick(1, 0, 0, 0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_count", 32'(fetch_count), 32'd0);

    // Release: first valid on 2nd edge with pc_out=0, then 1,2,3.
    tick(0, 1, 0, 0);                      // BOOT ignores stall
    chk("boot_bubble", 32'(instr_valid), 32'd0);
    tick(0, 0, 0, 0);
    chk("first_valid", 32'(instr_valid), 32'd1);
    chk("first_pc", 32'(pc_out), 32'd0);
    tick(0, 0, 0, 0);
    chk("seq_pc1", 32'(pc_out), 32'd1);
    tick(0, 0, 0, 0);
    chk("seq_pc2", 32'(pc_out), 32'd2);
    chk("count_at_2", 32'(fetch_count), 32'd3);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("seq_pc4", 32'(pc_out), 32'd4);

    // One-cycle stall with pc_out=4 in IF/ID.
    tick(0, 1, 0, 0);
    chk("stall1_hold", 32'(pc_out), 32'd4);
    tick(0, 0, 0, 0);
    chk("stall1_pc5", 32'(pc_out), 32'd5);
    chk("stall1_v5", 32'(instr_valid), 32'd1);
    tick(0, 0, 0, 0);
    chk("stall1_pc6", 32'(pc_out), 32'd6);

    // Five-cycle stall.
    c0 = fetch_count; p0 = pc_out;
    for (int i = 0; i < 5; i++) tick(0, 1, 0, 0);
    chk("stall5_hold", 32'(pc_out), 32'(p0));
    chk("stall5_cnt", 32'(fetch_count), 32'(c0));
    tick(0, 0, 0, 0);
    chk("stall5_skid", 32'(pc_out), 32'(p0 + 12'd1));
    chk("stall5_cnt1", 32'(fetch_count), 32'(c0 + 16'd1));
    tick(0, 0, 0, 0);
    chk("stall5_next", 32'(pc_out), 32'(p0 + 12'd2));
    chk("stall5_cnt2", 32'(fetch_count), 32'(c0 + 16'd2));

    // Redirect to 0x020 while stalled with a full skid.
    tick(0, 1, 0, 0);
    tick(0, 1, 1, 12'h020);
    chk("br_bub1", 32'(instr_valid), 32'd0);
    tick(0, 0, 0, 0);
    chk("br_bub2", 32'(instr_valid), 32'd0);
    tick(0, 0, 0, 0);
    chk("br_tgt", 32'(pc_out), 32'h020);
    chk("br_tgt_v", 32'(instr_valid), 32'd1);
    tick(0, 0, 0, 0);
    chk("br_tgt1", 32'(pc_out), 32'h021);

    // PC wrap.
    tick(0, 0, 1, 12'd4094);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("wrap_4094", 32'(pc_out), 32'd4094);
    tick(0, 0, 0, 0);
    chk("wrap_4095", 32'(pc_out), 32'd4095);
    tick(0, 0, 0, 0);
    chk("wrap_0", 32'(pc_out), 32'd0);
    tick(0, 0, 0, 0);
    chk("wrap_1", 32'(pc_out), 32'd1);

    // Reset pulse while stalled with a full skid.
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    tick(1, 1, 0, 0);
    chk("rst_mid_instr", 32'(instr_out), 32'd0);
    chk("rst_mid_pc", 32'(pc_out), 32'd0);
    chk("rst_mid_cnt", 32'(fetch_count), 32'd0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("rst_mid_first", 32'(pc_out), 32'd0);
    chk("rst_mid_firstv", 32'(instr_valid), 32'd1);

    // Randomized run with fresh memory contents.
    salt = 19'($urandom);
    tick(1, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 99) < 1);
      s = ($urandom_range(0, 99) < 35);
      b = ($urandom_range(0, 99) < 6);
      tick(r, s, b, 12'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL expose these ports (name  direction  width  meaning), clock and reset first:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard stall from decode; hold IF/ID and PC.
- branch_taken  in  1  redirect request from execute stage.
- branch_target  in  12  redirect PC.
- imem_addr  out  12  instruction memory address; equals PC register.
- imem_rd  out  1  memory read enable.
- imem_data  in  19  synchronous memory read data, valid one cycle after imem_addr.
- instr_out  out  19  IF/ID instruction; bits [18:13] are the 6-bit opcode consumed by the decode controller.
- pc_out  out  12  address of instr_out.
- instr_valid  out  1  IF/ID holds a real instruction; 0 = bubble.
- fetch_count  out  16  number of instructions loaded into IF/ID since reset.
REQ-002 Clocking and reset are fixed: one clock; reset is synchronous and active-high.

Function
REQ-003 Internal state SHALL be: pc (12), req_pc (12), req_valid (1), skid buffer {instr 19, pc 12, full 1}, IF/ID register, fetch_count, and a 3-state FSM BOOT, RUN, STALLED.
REQ-004 imem_addr SHALL equal pc combinationally; imem_rd SHALL be 1 whenever rst is 0.
REQ-005 BOOT SHALL last exactly one cycle after reset release, then move to RUN; stall is ignored in BOOT, and branch_taken is obeyed.
REQ-006 In BOOT and RUN with stall=0 and branch_taken=0: pc <= pc+1 (modulo 4096, 4095 wraps to 0), req_pc <= pc, req_valid <= 1.
REQ-007 In RUN with stall=0: if req_valid, IF/ID <= {imem_data, req_pc, valid=1}; otherwise instr_valid <= 0.
REQ-008 RUN with stall=1 SHALL go to STALLED: IF/ID and pc hold; if req_valid, skid <= {imem_data, req_pc}, full=1; req_valid <= 0.
REQ-009 STALLED with stall=1 SHALL hold everything; no memory data is captured.
REQ-010 STALLED with stall=0 SHALL go to RUN:
- IF/ID <= skid contents if full, else bubble.
- skid full <= 0.
- pc <= pc+1, req_pc <= pc, req_valid <= 1.
- A 1-cycle stall therefore inserts zero bubbles and drops or duplicates no instruction.
REQ-011 branch_taken=1 SHALL take priority over stall in every state:
- pc <= branch_target; req_valid <= 0; skid full <= 0; instr_valid <= 0; FSM -> RUN.
- The target instruction reaches IF/ID two cycles after the redirect edge, giving a 2-bubble penalty.
REQ-012 When instr_valid is 0, instr_out and pc_out SHALL hold their previous values.
REQ-013 fetch_count SHALL increment by 1 (wrapping at 65535 to 0) on each edge that loads a valid instruction into IF/ID, and SHALL hold otherwise.

Reset
REQ-014 With rst=1 at a rising edge, regardless of state or in-flight stall/branch:
- pc=0, req_pc=0, req_valid=0, skid full=0.
- instr_out=0, pc_out=0, instr_valid=0, fetch_count=0.
- FSM=BOOT.
REQ-015 Reset asserted mid-stall or mid-redirect SHALL discard all buffered data; the first valid instruction after release SHALL be address 0.

Structure
REQ-016 INSTR_W=19, PC_W=12, OPCODE field position [18:13], and the fetch FSM enum SHALL live in the shared defines package alongside the existing opcode constants.
REQ-017 The skid buffer (capture, hold, drain, clear) SHALL be one sub-module named fetch_skid_buffer; the rest stays in fetch_stage.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Reset release, memory word = 19'h0+addr, no stall: instr_valid first rises on the 2nd edge after release with pc_out=0, then pc_out=1,2,3 on consecutive cycles; fetch_count=3 after pc_out=2.
- Stall for 1 cycle while pc_out=4 is in IF/ID: IF/ID holds 4 for one extra cycle, then shows 5, 6 with no gap and no repeat.
- Stall for 5 cycles: IF/ID holds; on release shows the skid entry, then the next sequential word; fetch_count advances by exactly 1 per new instruction.
- branch_taken with target 12'h020 while stall=1: two bubbles (instr_valid=0), then pc_out=0x020, 0x021; the skid content is never output.
- pc running from 4094: pc_out sequence 4094, 4095, 0, 1.
- rst pulse during STALLED with a full skid: all outputs read zero; after release the first valid pc_out=0.
